// File: rtl/hub75_rx_pkg.sv
// hub75_rx_pkg
// Shared definitions for the HUB75 receiver: drain FSM encoding, default
// image geometry and the HUB75 field widths.
package hub75_rx_pkg;

    // Default image geometry: two chained 64-column panels.
    localparam int DEF_PANEL_WIDTH    = 64;
    localparam int DEF_NUM_PANELS     = 2;
    localparam int DEF_IMG_WIDTH      = DEF_PANEL_WIDTH * DEF_NUM_PANELS;
    localparam int DEF_IMG_WIDTH_LOG2 = 7;

    // HUB75 field widths.
    localparam int RGB_W = 3;          // {r,g,b} per half
    localparam int ROW_W = 4;          // row address
    localparam int PIX_W = 2 * RGB_W;  // {rgb1, rgb2}

    // Drain FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } drain_state_t;

endpackage

// File: rtl/hub75_rx_sync.sv
// hub75_sync
// Two-flop synchronizer for one HUB75 bundle (a strobe plus its data bits)
// followed by a rising-edge detector on the synchronized strobe. Strobe and
// data go through identical flop chains so the data seen in the edge cycle
// is the data that was stable on the wire when the strobe rose.
//
// Ports:
//   clk_in    system clock
//   rst       asynchronous active-low reset
//   strobe    asynchronous strobe (sclk or lat)
//   data      asynchronous data bits travelling with the strobe
//   data_sync synchronized data bits
//   rise      one-cycle pulse on a rising edge of the synchronized strobe
module hub75_sync #(
    parameter int DW = 1
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          strobe,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] data_sync,
    output logic          rise
);

    logic [DW-1:0] data_meta;
    logic          strobe_meta;
    logic          strobe_sync;
    logic          strobe_prev;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            data_meta   <= '0;
            data_sync   <= '0;
            strobe_meta <= 1'b0;
            strobe_sync <= 1'b0;
            strobe_prev <= 1'b0;
        end else begin
            data_meta   <= data;
            data_sync   <= data_meta;
            strobe_meta <= strobe;
            strobe_sync <= strobe_meta;
            strobe_prev <= strobe_sync;
        end
    end

    assign rise = strobe_sync & ~strobe_prev;

endmodule

// File: rtl/hub75_rx.sv
// hub75_rx
// HUB75 panel-chain receiver. Pixels shifted in on sclk are written into a
// capture buffer; a latch copies the capture buffer into a hold buffer and
// a drain FSM streams the held row out over a valid/ready write port.
// Capture and drain run concurrently since the buffers are separate.
//
// Handshake: a write transfers on a cycle where wr_en & wr_ready are both
// high. While wr_en is high and wr_ready is low, wr_addr and wr_data hold.
//
// Ports:
//   clk_in      system clock (>= 4x sclk)
//   rst         asynchronous active-low reset
//   sclk        HUB75 shift clock (asynchronous)
//   rgb1, rgb2  upper/lower half pixel bits {r,g,b}
//   lat         HUB75 latch
//   led_addr    HUB75 row address
//   wr_en       pixel write valid
//   wr_ready    sink accepts the write this cycle
//   wr_addr     {row, col}
//   wr_data     {rgb1, rgb2}
//   frame_done  one-cycle pulse after the last pixel of row 15 is accepted
//   overrun     sticky: a latch arrived while a row was still draining
//   len_err     sticky: a row had the wrong number of shifts
//   dbg_state   current drain FSM state
module hub75_rx
    import hub75_rx_pkg::*;
#(
    parameter int num_panels     = DEF_NUM_PANELS,
    parameter int panel_width    = DEF_PANEL_WIDTH,
    parameter int img_width      = panel_width * num_panels,
    parameter int img_width_log2 = DEF_IMG_WIDTH_LOG2
) (
    input  logic                      clk_in,
    input  logic                      rst,
    input  logic                      sclk,
    input  logic [2:0]                rgb1,
    input  logic [2:0]                rgb2,
    input  logic                      lat,
    input  logic [3:0]                led_addr,
    output logic                      wr_en,
    input  logic                      wr_ready,
    output logic [img_width_log2+3:0] wr_addr,
    output logic [5:0]                wr_data,
    output logic                      frame_done,
    output logic                      overrun,
    output logic                      len_err,
    output logic [1:0]                dbg_state
);

    localparam int AW = img_width_log2;
    localparam int CW = img_width_log2 + 1;  // col_cnt must reach img_width

    // Synchronized bundles.
    logic [PIX_W-1:0] s_pix;
    logic             s_rise;
    logic [ROW_W-1:0] l_addr;
    logic             l_rise;

    hub75_sync #(.DW(PIX_W)) u_sync_shift (
        .clk_in    (clk_in),
        .rst       (rst),
        .strobe    (sclk),
        .data      ({rgb1, rgb2}),
        .data_sync (s_pix),
        .rise      (s_rise)
    );

    hub75_sync #(.DW(ROW_W)) u_sync_latch (
        .clk_in    (clk_in),
        .rst       (rst),
        .strobe    (lat),
        .data      (led_addr),
        .data_sync (l_addr),
        .rise      (l_rise)
    );

    // Capture side.
    logic [CW-1:0]    col_cnt;
    logic [CW-1:0]    cnt_after;
    logic             shift_store;
    logic             latch_take;
    logic [PIX_W-1:0] cap_buf  [img_width];
    logic [PIX_W-1:0] hold_buf [img_width];

    // Drain side.
    drain_state_t     state, state_n;
    logic [AW-1:0]    idx, idx_n;
    logic [ROW_W-1:0] row, row_n;

    assign shift_store = s_rise && (col_cnt < CW'(img_width));
    assign latch_take  = l_rise && (state == ST_IDLE);
    // Column count including a shift landing in the same cycle as the latch.
    assign cnt_after   = shift_store ? col_cnt + 1'b1 : col_cnt;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            col_cnt <= '0;
            overrun <= 1'b0;
            len_err <= 1'b0;
        end else begin
            if (s_rise && !shift_store)
                len_err <= 1'b1;
            if (l_rise) begin
                col_cnt <= '0;
                if (state == ST_IDLE) begin
                    if (cnt_after != CW'(img_width))
                        len_err <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (shift_store) begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Buffers carry no reset. The hold copy folds in a pixel arriving in
    // the latch cycle so that pixel is part of the latched row.
    always_ff @(posedge clk_in) begin
        if (shift_store)
            cap_buf[col_cnt[AW-1:0]] <= s_pix;
        if (latch_take) begin
            for (int i = 0; i < img_width; i++) begin
                hold_buf[i] <= (shift_store && col_cnt[AW-1:0] == AW'(i))
                               ? s_pix : cap_buf[i];
            end
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            row   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            row   <= row_n;
        end
    end

    // Drain FSM next state and outputs. Outputs are zero outside DRAIN so
    // a reset immediately silences the write port.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        row_n      = row;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (latch_take) begin
                    state_n = ST_DRAIN;
                    idx_n   = '0;
                    row_n   = l_addr;
                end
            end
            ST_DRAIN: begin
                wr_en   = 1'b1;
                wr_addr = {row, idx};
                wr_data = hold_buf[idx];
                if (wr_ready) begin
                    if (idx == AW'(img_width - 1))
                        state_n = ST_DONE;
                    else
                        idx_n = idx + 1'b1;
                end
            end
            ST_DONE: begin
                frame_done = (row == 4'hF);
                state_n    = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign dbg_state = state;

endmodule
